word_fifo_byte_tx: RTL and testbench

- Downstream neighbour of the Ethernet core data generator.
- Accepts 32-bit words on a write strobe and buffers them in an on-chip FIFO.
- Returns FIFO full/empty status to the producer.
- Serializes each buffered word into four bytes, LSB first, on a valid/ready byte stream that feeds the TCP transmit path.

---
 rtl/word_fifo_byte_tx_pkg.sv | 28 ++
 rtl/word_fifo_byte_tx_ram.sv | 39 +++
 rtl/word_fifo_byte_tx.sv | 182 ++++++++++++++++++
 tb/tb_word_fifo_byte_tx.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/word_fifo_byte_tx_pkg.sv
// ---------------------------------------------------------------------------
// word_fifo_byte_tx_pkg
//   Shared definitions for the word FIFO / byte serializer block:
//   serializer state encoding, bytes-per-word constants and a byte-lane
//   selection helper.
// ---------------------------------------------------------------------------
package word_fifo_byte_tx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } tx_state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned IDX_BITS       = 2;

  typedef logic [IDX_BITS-1:0] byte_idx_t;

  localparam byte_idx_t LAST_IDX = byte_idx_t'(BYTES_PER_WORD - 1);

  // Byte lane idx of a 32-bit word, lane 0 being the least significant byte.
  function automatic logic [7:0] word_byte(input logic [31:0] word,
                                           input byte_idx_t   idx);
    return word[8*idx +: 8];
  endfunction

endpackage

// File: rtl/word_fifo_byte_tx_ram.sv
// ---------------------------------------------------------------------------
// word_fifo_ram
//   Simple dual-port RAM, 2**ADDR_BITS x DATA_BITS, one write port and one
//   registered read port (one cycle read latency). Array contents are not
//   reset.
//
//   clk      : clock
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable; rd_data updates on the following edge
//   rd_addr  : read address
//   rd_data  : registered read data
// ---------------------------------------------------------------------------
module word_fifo_ram #(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned DATA_BITS = 32
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/word_fifo_byte_tx.sv
// ---------------------------------------------------------------------------
// word_fifo_byte_tx
//   Buffers 32-bit words from the producer in an on-chip FIFO and serializes
//   each word into four bytes, least significant byte first, on a
//   valid/ready byte stream.
//
//   BUS_CLK      : clock
//   RESET_N      : asynchronous active-low reset
//   FIFO_WRITE   : producer write strobe (one word per cycle)
//   FIFO_DATA    : producer data word
//   FIFO_FULL    : FIFO holds DEPTH words
//   FIFO_EMPTY   : FIFO holds no words
//   FILL_COUNT   : words stored in the FIFO (not counting the serializer)
//   OVERFLOW_CNT : writes dropped while full, saturating
//   TX_READY     : byte sink ready
//   TX_VALID     : byte valid
//   TX_DATA      : byte data
// ---------------------------------------------------------------------------
module word_fifo_byte_tx
  import word_fifo_byte_tx_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 10,
  parameter int unsigned OVF_BITS  = 16
) (
  input  logic                BUS_CLK,
  input  logic                RESET_N,
  input  logic                FIFO_WRITE,
  input  logic [31:0]         FIFO_DATA,
  output logic                FIFO_FULL,
  output logic                FIFO_EMPTY,
  output logic [ADDR_BITS:0]  FILL_COUNT,
  output logic [OVF_BITS-1:0] OVERFLOW_CNT,
  input  logic                TX_READY,
  output logic                TX_VALID,
  output logic [7:0]          TX_DATA
);

  localparam logic [ADDR_BITS:0] DEPTH_CNT = {1'b1, {ADDR_BITS{1'b0}}};

  logic [ADDR_BITS-1:0] wr_ptr;
  logic [ADDR_BITS-1:0] rd_ptr;
  logic [ADDR_BITS:0]   count;
  logic [OVF_BITS-1:0]  ovf_cnt;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 drop;

  tx_state_e            state;
  tx_state_e            state_next;
  logic                 pop;
  logic                 load_word;
  logic                 advance;
  byte_idx_t            idx;
  byte_idx_t            idx_inc;
  logic [31:0]          shreg;
  logic [31:0]          ram_rd_data;
  logic                 tx_valid;
  logic [7:0]           tx_data;

  // Full is judged on the registered count, before any same-cycle pop, so a
  // write arriving while full is dropped even if a word leaves that cycle.
  assign full   = (count == DEPTH_CNT);
  assign empty  = (count == '0);
  assign accept = FIFO_WRITE && !full;
  assign drop   = FIFO_WRITE && full;

  assign FIFO_FULL    = full;
  assign FIFO_EMPTY   = empty;
  assign FILL_COUNT   = count;
  assign OVERFLOW_CNT = ovf_cnt;
  assign TX_VALID     = tx_valid;
  assign TX_DATA      = tx_data;

  // ------------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------------
  word_fifo_ram #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_BITS (32)
  ) u_ram (
    .clk     (BUS_CLK),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (FIFO_DATA),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (ram_rd_data)
  );

  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ovf_cnt <= '0;
    end else begin
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------------
  // Serializer
  // ------------------------------------------------------------------------
  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  assign idx_inc = idx + 1'b1;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    load_word  = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        load_word  = 1'b1;
        state_next = SEND;
      end
      SEND: begin
        if (TX_READY) begin
          if (idx != LAST_IDX) begin
            advance = 1'b1;
          end else if (!empty) begin
            pop        = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // TX_DATA is registered one step ahead: it is loaded with the byte the
  // state machine will present next, so it only moves on load or on an
  // accepted byte and holds steady through a stall.
  always_ff @(posedge BUS_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      shreg    <= '0;
      idx      <= '0;
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_valid <= (state_next == SEND);
      if (load_word) begin
        shreg   <= ram_rd_data;
        idx     <= '0;
        tx_data <= word_byte(ram_rd_data, '0);
      end else if (advance) begin
        idx     <= idx_inc;
        tx_data <= word_byte(shreg, idx_inc);
      end
    end
  end

endmodule

// File: tb/tb_word_fifo_byte_tx.sv
module tb_word_fifo_byte_tx;

  localparam int ADDR_BITS = 4;
  localparam int OVF_BITS  = 4;
  localparam int DEPTH     = 16;
  localparam int OVF_MAX   = 15;

  logic                BUS_CLK = 1'b0;
  logic                RESET_N = 1'b0;
  logic                FIFO_WRITE = 1'b0;
  logic [31:0]         FIFO_DATA = '0;
  logic                FIFO_FULL;
  logic                FIFO_EMPTY;
  logic [ADDR_BITS:0]  FILL_COUNT;
  logic [OVF_BITS-1:0] OVERFLOW_CNT;
  logic                TX_READY = 1'b0;
  logic                TX_VALID;
  logic [7:0]          TX_DATA;

  word_fifo_byte_tx #(
    .ADDR_BITS (ADDR_BITS),
    .OVF_BITS  (OVF_BITS)
  ) dut (
    .BUS_CLK      (BUS_CLK),
    .RESET_N      (RESET_N),
    .FIFO_WRITE   (FIFO_WRITE),
    .FIFO_DATA    (FIFO_DATA),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_EMPTY   (FIFO_EMPTY),
    .FILL_COUNT   (FILL_COUNT),
    .OVERFLOW_CNT (OVERFLOW_CNT),
    .TX_READY     (TX_READY),
    .TX_VALID     (TX_VALID),
    .TX_DATA      (TX_DATA)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int checks   = 0;
  int failures = 0;
  int rx_count = 0;

  // Scoreboard of bytes the sink must see, in order.
  logic [7:0] sb[$];

  // Reference model: words waiting in the FIFO, bytes still to be shown by
  // the serializer (including the one on the bus), a word in flight from the
  // FIFO to the serializer, and the dropped-write counter.
  int m_fill    = 0;
  int m_left    = 0;
  bit m_loading = 1'b0;
  int m_ovf     = 0;

  task automatic chk(input string name, input longint unsigned act,
                     input longint unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge. Checks the current outputs
  // against the model, drives this cycle's inputs, advances the model to
  // the next edge and waits for it.
  task automatic do_cycle(input logic wr, input logic [31:0] d,
                          input logic rdy);
    bit acc;
    bit pop;
    chk("fill_count", FILL_COUNT, m_fill);
    chk("fifo_full", FIFO_FULL, (m_fill == DEPTH));
    chk("fifo_empty", FIFO_EMPTY, (m_fill == 0));
    chk("overflow_cnt", OVERFLOW_CNT, m_ovf);
    chk("tx_valid", TX_VALID, (m_left > 0));

    FIFO_WRITE = wr;
    FIFO_DATA  = d;
    TX_READY   = rdy;

    acc = wr && (m_fill < DEPTH);
    if (wr && !acc && m_ovf < OVF_MAX) m_ovf++;
    if (acc) begin
      for (int b = 0; b < 4; b++) sb.push_back(d[8*b +: 8]);
    end

    pop = 1'b0;
    if (m_loading) begin
      m_loading = 1'b0;
      m_left    = 4;
    end else if (m_left == 0) begin
      pop = (m_fill != 0);
    end else if (rdy) begin
      m_left--;
      if (m_left == 0) pop = (m_fill != 0);
    end
    if (pop) m_loading = 1'b1;
    m_fill = m_fill + int'(acc) - int'(pop);

    @(posedge BUS_CLK);
    #1;
  endtask

  task automatic drain(input bit random_ready);
    int n;
    n = 0;
    while (!(m_fill == 0 && m_left == 0 && !m_loading) && n < 3000) begin
      do_cycle(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk("drain_done_in_budget", (n < 3000), 1);
    do_cycle(1'b0, '0, 1'b1);
  endtask

  // Monitor: pops the scoreboard on each accepted byte and checks that a
  // stalled byte is held stable.
  initial begin
    logic       prev_stall;
    logic [7:0] prev_data;
    logic [7:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge BUS_CLK);
      if (!RESET_N) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid", TX_VALID, 1);
          chk("stall_data", TX_DATA, prev_data);
        end
        if (TX_VALID && TX_READY) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_byte: got %0h expected none at %0t",
                     TX_DATA, $time);
          end else begin
            exp = sb.pop_front();
            chk("tx_byte", TX_DATA, exp);
          end
          rx_count++;
        end
        prev_stall = TX_VALID && !TX_READY;
        prev_data  = TX_DATA;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int sent;
    int rx0;
    int n;

    // Reset values
    repeat (3) @(posedge BUS_CLK);
    #1;
    chk("rst_tx_valid", TX_VALID, 0);
    chk("rst_tx_data", TX_DATA, 0);
    chk("rst_empty", FIFO_EMPTY, 1);
    chk("rst_full", FIFO_FULL, 0);
    chk("rst_fill", FILL_COUNT, 0);
    chk("rst_ovf", OVERFLOW_CNT, 0);
    @(negedge BUS_CLK);
    RESET_N = 1'b1;
    @(posedge BUS_CLK);
    #1;

    // Single word, latency and byte order
    rx0 = rx_count;
    do_cycle(1'b1, 32'h4433_2211, 1'b1);
    chk("lat_n1_valid", TX_VALID, 0);
    do_cycle(1'b0, '0, 1'b1);
    chk("lat_n2_valid", TX_VALID, 0);
    do_cycle(1'b0, '0, 1'b1);
    chk("lat_n3_valid", TX_VALID, 1);
    chk("lat_n3_byte", TX_DATA, 8'h11);
    drain(1'b0);
    chk("single_bytes", rx_count - rx0, 4);
    chk("single_empty", FIFO_EMPTY, 1);
    chk("single_idle", TX_VALID, 0);

    // Backpressure: counter words 0..99 with random ready
    rx0  = rx_count;
    sent = 0;
    n    = 0;
    while (sent < 100 && n < 5000) begin
      logic w;
      w = (m_fill < DEPTH) && ($urandom_range(0, 3) != 0);
      do_cycle(w, sent, 1'($urandom_range(0, 1)));
      if (w) sent++;
      n++;
    end
    chk("bp_all_sent", sent, 100);
    drain(1'b1);
    chk("bp_byte_total", rx_count - rx0, 400);

    // Simultaneous accept and pop at count 1
    do_cycle(1'b1, 32'hC000_0000, 1'b1);
    do_cycle(1'b1, 32'hC000_0001, 1'b1);
    chk("simul_fill_a", FILL_COUNT, 1);
    for (int k = 2; k < 12; k++) begin
      repeat (4) do_cycle(1'b0, '0, 1'b1);
      do_cycle(1'b1, 32'hC000_0000 + k, 1'b1);
      chk("simul_fill", FILL_COUNT, 1);
    end
    drain(1'b0);

    // Wrap-around: 50 words streamed continuously
    rx0  = rx_count;
    sent = 0;
    n    = 0;
    while (sent < 50 && n < 2000) begin
      logic w;
      w = (m_fill < DEPTH);
      do_cycle(w, 32'hB000_0000 + sent, 1'b1);
      if (w) sent++;
      n++;
    end
    drain(1'b0);
    chk("wrap_bytes", rx_count - rx0, 200);
    chk("wrap_fill_zero", FILL_COUNT, 0);

    // Fill and overflow
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'hF000_0000 + i, 1'b0);
    chk("ovf_fill16", FILL_COUNT, 16);
    chk("ovf_full", FIFO_FULL, 1);
    chk("ovf_cnt3", OVERFLOW_CNT, 3);
    chk("ovf_valid_stalled", TX_VALID, 1);
    chk("ovf_first_byte", TX_DATA, 8'h00);
    // Keep writing as the first pops happen: writes coinciding with a pop
    // from a full FIFO are dropped.
    for (int i = 0; i < 12; i++) do_cycle(1'b1, 32'hE000_0000 + i, 1'b1);
    for (int i = 0; i < 20; i++) do_cycle(1'b1, 32'hD000_0000 + i, 1'b0);
    chk("ovf_saturated", OVERFLOW_CNT, OVF_MAX);
    drain(1'b0);

    // Asynchronous reset at byte index 2
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 32'h9000_0000 + i, 1'b0);
    n = 0;
    while (!(m_left == 2 && !m_loading) && n < 20) begin
      do_cycle(1'b0, '0, 1'b1);
      n++;
    end
    chk("reach_idx2", m_left, 2);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("arst_tx_valid", TX_VALID, 0);
    chk("arst_empty", FIFO_EMPTY, 1);
    chk("arst_fill", FILL_COUNT, 0);
    chk("arst_ovf", OVERFLOW_CNT, 0);
    chk("arst_tx_data", TX_DATA, 0);
    sb.delete();
    m_fill    = 0;
    m_left    = 0;
    m_loading = 1'b0;
    m_ovf     = 0;
    FIFO_WRITE = 1'b0;
    TX_READY   = 1'b0;
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK);
    RESET_N = 1'b1;
    @(posedge BUS_CLK);
    #1;
    rx0 = rx_count;
    do_cycle(1'b1, 32'hA5A5_0001, 1'b1);
    drain(1'b1);
    chk("post_reset_bytes", rx_count - rx0, 4);

    chk("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
